hc_rw_sequencer: RTL and testbench
==================================

// Module: hc_rw_sequencer
// PURPOSE
//  Sequences a multi-line AFU job over CCI-P: issues NUM_LINES cache-line reads from src_addr (c0).
//  Buffers the returned lines and writes each to dst_addr at the same line offset (c1).
//  Then posts the completion flag (data=1) to DSM line dsm_addr+1.
//  Sits between the MMIO CSR block (start/stop/addresses) and the registered sTx/sRx channel fields.
// PARAMETERS
//  ADDR_W      42  cache-line address width (t_ccip_clAddr)
//  CNT_W       16  line-count width; line index is carried in mdata, so CNT_W<=16
//  FIFO_DEPTH  8   response buffer depth (power of 2); also the max in-flight lines (credit limit)
// PORTS
//  clk           in   1       CCI-P clock (pClk)
//  reset         in   1       synchronous, active-high (pck_cp2af_softReset)
//  start         in   1       1-cycle pulse: ctl write == HC_CONTROL_START
//  stop          in   1       1-cycle pulse: ctl write == HC_CONTROL_STOP
//  src_addr      in   ADDR_W  read buffer base (line address)
//  dst_addr      in   ADDR_W  write buffer base (line address)
//  dsm_addr      in   ADDR_W  DSM base (line address)
//  num_lines     in   CNT_W   lines to move; sampled on start
//  c0_alm_full   in   1       sRx.c0TxAlmFull
//  c1_alm_full   in   1       sRx.c1TxAlmFull
//  rd_req_valid  out  1       -> sTx.c0.valid
//  rd_req_addr   out  ADDR_W  -> sTx.c0.hdr.address
//  rd_req_mdata  out  16      -> sTx.c0.hdr.mdata (line index)
//  rd_rsp_valid  in   1       sRx.c0.rspValid && resp_type==eRSP_RDLINE
//  rd_rsp_mdata  in   16      sRx.c0.hdr.mdata
//  rd_rsp_data   in   512     sRx.c0.data (any compute stage is upstream of this port)
//  wr_req_valid  out  1       -> sTx.c1.valid (sop=1 set by top)
//  wr_req_addr   out  ADDR_W  -> sTx.c1.hdr.address
//  wr_req_data   out  512     -> sTx.c1.data
//  busy          out  1       job in RUN or FLAG
//  done          out  1       completion flag written; held until stop
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE; rd/wr valid=0; busy=0; done=0; counters, credits, FIFO ptrs=0.
//  FSM:
//   IDLE -start-> RUN (latch num_lines as n).
//     If n==0, go straight to FLAG instead.
//   RUN -(wr_cnt==n)-> FLAG.
//   FLAG -(flag write issued)-> DONE.
//   DONE -stop-> IDLE.
//   start outside IDLE is ignored; stop outside DONE is ignored. Abort is reset only.
//  Read issue (RUN): a read fires in a cycle when all hold:
//   rd_cnt<n, credits<FIFO_DEPTH, !c0_alm_full.
//   Next cycle: rd_req_valid=1, addr=src_addr+rd_cnt, mdata=rd_cnt. Then rd_cnt++ and credits++.
//  Response: every rd_rsp_valid pushes {mdata,data} into the FIFO.
//   Credits guarantee no overflow; a push while full is an assertion failure.
//   Responses may return out of order; the write address comes from mdata, not arrival order.
//  Write issue (RUN): fires when FIFO non-empty && !c1_alm_full.
//   Next cycle: wr_req_valid=1, addr=dst_addr+idx, data=FIFO head. Pop, wr_cnt++, credits--.
//  Credits: a read issue and a write issue in the same cycle leave credits unchanged.
//   A push and a pop in the same cycle are both honoured. FIFO pointers wrap mod FIFO_DEPTH.
//  Flag (FLAG): fires when !c1_alm_full.
//   Next cycle: wr_req_valid=1, addr=dsm_addr+1, data=512'h1. done=1 from the following cycle.
//   Flag write is never issued before the last data write.
//  Address adds are modulo 2^ADDR_W. Counters are CNT_W wide; n=2^CNT_W-1 is legal.
//  Latency: start to first rd_req_valid = 2 cycles. rd_rsp_valid to its wr_req_valid >= 2 cycles when uncongested.
//  Reset mid-job drops all state; late responses arriving in IDLE are discarded (no push).
// TESTING
//  T1 n=1, src=0x100, dst=0x200, dsm=0x40:
//     one read addr 0x100 mdata 0; rsp -> write addr 0x200 same data;
//     then write 0x41 data 1; done=1; stop -> busy=0, done=0.
//  T2 n=20, FIFO_DEPTH=8, responses withheld: exactly 8 reads issued, then stall.
//     Release responses -> all 20 reads/writes issued; credits never exceed 8.
//  T3 n=4, responses returned in order mdata 3,1,0,2 -> writes to dst+3,+1,+0,+2 with matching data.
//     Flag write comes after all four.
//  T4 c1_alm_full held high for 50 cycles mid-job: no wr_req_valid while high; FIFO fills to 8; no overflow.
//     After release, all lines written exactly once.
//  T5 start with n=0 -> no reads; flag write to dsm+1 within 3 cycles.
//     A second start while busy is ignored; stop while RUN is ignored.
//  T6 reset asserted with 5 lines in flight -> next cycle all outputs 0, state IDLE.
//     Stray rd_rsp_valid afterwards causes no write.

Source files
------------

// File: rtl/hc_rw_sequencer_if.sv
// Channel bundle between the MMIO/CCI-P shell and hc_rw_sequencer: job control,
// c0 read request/response, c1 write request and job status.
interface hc_rw_sequencer_if #(
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] dsm_addr;
  logic [CNT_W-1:0]  num_lines;
  logic              c0_alm_full;
  logic              c1_alm_full;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [15:0]       rd_req_mdata;
  logic              rd_rsp_valid;
  logic [15:0]       rd_rsp_mdata;
  logic [511:0]      rd_rsp_data;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [511:0]      wr_req_data;
  logic              busy;
  logic              done;

  modport slave (
    input  start, stop, src_addr, dst_addr, dsm_addr, num_lines,
    input  c0_alm_full, c1_alm_full,
    input  rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    output rd_req_valid, rd_req_addr, rd_req_mdata,
    output wr_req_valid, wr_req_addr, wr_req_data,
    output busy, done
  );

  modport master (
    output start, stop, src_addr, dst_addr, dsm_addr, num_lines,
    output c0_alm_full, c1_alm_full,
    output rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    input  rd_req_valid, rd_req_addr, rd_req_mdata,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    input  busy, done
  );
endinterface

// File: rtl/hc_rw_sequencer.sv
// Multi-line copy job over CCI-P: credit-limited c0 reads, response buffer,
// c1 writes to the same line offset, then a completion flag to DSM line +1.
module hc_rw_sequencer #(
  parameter int unsigned ADDR_W     = 42,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  hc_rw_sequencer_if.slave  bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLAG, S_DONE} state_t;

  typedef struct packed {
    logic [15:0]  mdata;
    logic [511:0] data;
  } entry_t;

  state_t            state_q;
  logic [CNT_W-1:0]  n_q, rd_cnt_q, wr_cnt_q;
  logic [CW-1:0]     credits_q, credits_d;
  logic [CW-1:0]     wptr_q, rptr_q;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            head;

  logic              rd_req_valid_q, wr_req_valid_q;
  logic [ADDR_W-1:0] rd_req_addr_q, wr_req_addr_q;
  logic [15:0]       rd_req_mdata_q;
  logic [511:0]      wr_req_data_q;
  logic              busy_q, done_q;

  logic fifo_empty, fifo_full, push, rd_fire, wr_fire, flag_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    head       = mem_q[rptr_q[PW-1:0]];
    push       = bus.rd_rsp_valid && (state_q != S_IDLE);
    rd_fire    = (state_q == S_RUN) && (rd_cnt_q < n_q) &&
                 (credits_q < CW'(FIFO_DEPTH)) && !bus.c0_alm_full;
    wr_fire    = (state_q == S_RUN) && !fifo_empty && !bus.c1_alm_full;
    flag_fire  = (state_q == S_FLAG) && !bus.c1_alm_full;
    credits_d  = credits_q + CW'(rd_fire) - CW'(wr_fire);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PW-1:0]] <= {bus.rd_rsp_mdata, bus.rd_rsp_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      credits_q      <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_mdata_q <= '0;
      wr_req_valid_q <= 1'b0;
      wr_req_addr_q  <= '0;
      wr_req_data_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      credits_q      <= credits_d;
      rd_req_valid_q <= rd_fire;
      wr_req_valid_q <= wr_fire || flag_fire;
      if (push) wptr_q <= wptr_q + CW'(1);

      if (rd_fire) begin
        rd_req_addr_q  <= bus.src_addr + ADDR_W'(rd_cnt_q);
        rd_req_mdata_q <= 16'(rd_cnt_q);
        rd_cnt_q       <= rd_cnt_q + CNT_W'(1);
      end

      // The write address follows the line index in mdata, not arrival order.
      if (wr_fire) begin
        wr_req_addr_q <= bus.dst_addr + ADDR_W'(head.mdata[CNT_W-1:0]);
        wr_req_data_q <= head.data;
        rptr_q        <= rptr_q + CW'(1);
        wr_cnt_q      <= wr_cnt_q + CNT_W'(1);
      end else if (flag_fire) begin
        wr_req_addr_q <= bus.dsm_addr + ADDR_W'(1);
        wr_req_data_q <= 512'h1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            n_q      <= bus.num_lines;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= (bus.num_lines == '0) ? S_FLAG : S_RUN;
          end
        end
        S_RUN: begin
          if (wr_cnt_q == n_q) state_q <= S_FLAG;
        end
        S_FLAG: begin
          if (flag_fire) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.stop) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rd_req_valid = rd_req_valid_q;
    bus.rd_req_addr  = rd_req_addr_q;
    bus.rd_req_mdata = rd_req_mdata_q;
    bus.wr_req_valid = wr_req_valid_q;
    bus.wr_req_addr  = wr_req_addr_q;
    bus.wr_req_data  = wr_req_data_q;
    bus.busy         = busy_q;
    bus.done         = done_q;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_hc_rw_sequencer.sv
// Directed bench for hc_rw_sequencer: job flow, credit stall, out-of-order
// responses, write back-pressure, zero-length job and mid-job reset.
module tb_hc_rw_sequencer;
  localparam int unsigned AW = 42;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hc_rw_sequencer_if #(.ADDR_W(AW), .CNT_W(16)) bus ();

  hc_rw_sequencer #(.ADDR_W(AW), .CNT_W(16), .FIFO_DEPTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {logic [AW-1:0] addr; logic [15:0] mdata;} rd_t;
  typedef struct {logic [AW-1:0] addr; logic [511:0] data;} wr_t;

  rd_t           rd_log[$];
  wr_t           wr_log[$];
  logic [15:0]   pend[$];
  bit            auto_rsp;
  int            rd_total, wrd_total, max_out;
  logic [AW-1:0] cur_dsm;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input int unsigned i);
    logic [511:0] d;
    for (int unsigned k = 0; k < 16; k++) d[k*32 +: 32] = (32'h5A00_0000 | (k << 16)) ^ i;
    return d;
  endfunction

  // One clock: log outputs after the edge, then drive the in-order responder.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.rd_req_valid) begin
      rd_log.push_back('{bus.rd_req_addr, bus.rd_req_mdata});
      pend.push_back(bus.rd_req_mdata);
      rd_total++;
    end
    if (bus.wr_req_valid) begin
      wr_log.push_back('{bus.wr_req_addr, bus.wr_req_data});
      if (bus.wr_req_addr != cur_dsm + AW'(1)) wrd_total++;
    end
    if (rd_total - wrd_total > max_out) max_out = rd_total - wrd_total;
    bus.rd_rsp_valid = 1'b0;
    if (auto_rsp && pend.size() != 0) begin
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_mdata = pend.pop_front();
      bus.rd_rsp_data  = line_data(32'(bus.rd_rsp_mdata));
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); pend.delete();
    rd_total = 0; wrd_total = 0; max_out = 0;
  endtask

  task automatic do_reset();
    bus.start = 0; bus.stop = 0; bus.c0_alm_full = 0; bus.c1_alm_full = 0;
    bus.rd_rsp_valid = 0; bus.rd_rsp_mdata = '0; bus.rd_rsp_data = '0;
    auto_rsp = 0;
    reset = 1;
    step(); step();
    reset = 0;
    clear_logs();
  endtask

  task automatic start_job(input logic [AW-1:0] src, dst, dsm, input logic [15:0] n);
    bus.src_addr = src; bus.dst_addr = dst; bus.dsm_addr = dsm; bus.num_lines = n;
    cur_dsm = dsm;
    bus.start = 1;
    step();
    bus.start = 0;
  endtask

  task automatic wait_done(input string t, input int budget);
    int i = 0;
    while (bus.done !== 1'b1 && i < budget) begin step(); i++; end
    chk_eq({t, " done"}, bus.done, 1);
  endtask

  task automatic check_job(input string t, input int unsigned n,
                           input logic [AW-1:0] src, dst, dsm);
    int errs = 0;
    bit seen_r[];
    bit seen_w[];
    logic [AW-1:0] idx;
    seen_r = new[n];
    seen_w = new[n];
    chk_eq({t, " rd count"}, rd_log.size(), n);
    chk_eq({t, " wr count"}, wr_log.size(), n + 1);
    foreach (rd_log[i]) begin
      if (rd_log[i].mdata >= n || seen_r[rd_log[i].mdata] ||
          rd_log[i].addr !== src + AW'(rd_log[i].mdata)) errs++;
      else seen_r[rd_log[i].mdata] = 1;
    end
    for (int i = 0; i < wr_log.size() - 1 && i < int'(n); i++) begin
      idx = wr_log[i].addr - dst;
      if (idx >= AW'(n) || seen_w[idx] || wr_log[i].data !== line_data(32'(idx))) errs++;
      else seen_w[idx] = 1;
    end
    chk_eq({t, " line content"}, errs, 0);
    if (wr_log.size() != 0) begin
      chk_eq({t, " flag addr"}, wr_log[$].addr, dsm + AW'(1));
      chk_eq({t, " flag data"}, wr_log[$].data, 512'h1);
    end
  endtask

  initial begin
    logic [15:0] order [4];
    order = '{16'd3, 16'd1, 16'd0, 16'd2};
    cur_dsm = '0;

    // Reset state
    do_reset();
    chk_eq("rst outputs", {bus.rd_req_valid, bus.wr_req_valid, bus.busy, bus.done}, 4'b0000);

    // T1: single line, then stop
    start_job(42'h100, 42'h200, 42'h40, 16'd1);
    chk_eq("T1 no read after 1 cycle", rd_log.size(), 0);
    chk_eq("T1 busy", bus.busy, 1);
    auto_rsp = 1;
    step();
    chk_eq("T1 read at 2 cycles", rd_log.size(), 1);
    chk_eq("T1 rd addr", bus.rd_req_addr, 42'h100);
    chk_eq("T1 rd mdata", bus.rd_req_mdata, 16'h0);
    wait_done("T1", 50);
    check_job("T1", 1, 42'h100, 42'h200, 42'h40);
    chk_eq("T1 wr0 addr", wr_log[0].addr, 42'h200);
    chk_eq("T1 wr0 data", wr_log[0].data, line_data(0));
    step(); step(); step();
    chk_eq("T1 done held", {bus.done, bus.busy}, 2'b10);
    bus.stop = 1;
    step();
    bus.stop = 0;
    chk_eq("T1 after stop", {bus.done, bus.busy}, 2'b00);

    // T2: credit limit with responses withheld
    do_reset();
    start_job(42'h1000, 42'h2000, 42'h80, 16'd20);
    repeat (30) step();
    chk_eq("T2 stalled reads", rd_log.size(), 8);
    auto_rsp = 1;
    wait_done("T2", 600);
    check_job("T2", 20, 42'h1000, 42'h2000, 42'h80);
    chk_eq("T2 max credits", max_out, 8);

    // T3: out-of-order responses
    do_reset();
    start_job(42'h300, 42'h400, 42'hC0, 16'd4);
    repeat (6) step();
    chk_eq("T3 reads", rd_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      bus.rd_rsp_valid = 1;
      bus.rd_rsp_mdata = order[k];
      bus.rd_rsp_data  = line_data(32'(order[k]));
      step();
    end
    wait_done("T3", 50);
    check_job("T3", 4, 42'h300, 42'h400, 42'hC0);
    for (int k = 0; k < 4 && k < wr_log.size(); k++)
      chk_eq($sformatf("T3 wr%0d addr", k), wr_log[k].addr, 42'h400 + AW'(order[k]));

    // T4: c1 back-pressure for 50 cycles
    do_reset();
    bus.c1_alm_full = 1;
    auto_rsp = 1;
    start_job(42'h3FF_FFFF_FFFF, 42'h5000, 42'h100, 16'd16);
    repeat (50) step();
    chk_eq("T4 no writes", wr_log.size(), 0);
    chk_eq("T4 reads capped", rd_log.size(), 8);
    bus.c1_alm_full = 0;
    wait_done("T4", 600);
    check_job("T4", 16, 42'h3FF_FFFF_FFFF, 42'h5000, 42'h100);
    chk_eq("T4 max credits", max_out, 8);

    // T5: zero-length job, then start/stop ignored mid-job
    do_reset();
    start_job(42'h600, 42'h700, 42'h140, 16'd0);
    chk_eq("T5 busy", bus.busy, 1);
    step();
    chk_eq("T5 flag write", {bus.wr_req_valid, bus.done}, 2'b10);
    chk_eq("T5 flag addr", bus.wr_req_addr, 42'h141);
    chk_eq("T5 flag data", bus.wr_req_data, 512'h1);
    step();
    chk_eq("T5 done next", {bus.wr_req_valid, bus.done}, 2'b01);
    chk_eq("T5 no reads", rd_log.size(), 0);
    bus.stop = 1;
    step();
    bus.stop = 0;
    clear_logs();
    start_job(42'h800, 42'h900, 42'h180, 16'd2);
    repeat (5) step();
    bus.src_addr = 42'hA00;
    bus.num_lines = 16'd5;
    bus.start = 1;
    step();
    bus.start = 0;
    bus.src_addr = 42'h800;
    bus.stop = 1;
    step();
    bus.stop = 0;
    chk_eq("T5 stop ignored", {bus.busy, bus.done}, 2'b10);
    auto_rsp = 1;
    wait_done("T5b", 50);
    check_job("T5b", 2, 42'h800, 42'h900, 42'h180);

    // T6: reset with 5 lines in flight, stray responses afterwards
    do_reset();
    start_job(42'hB00, 42'hC00, 42'h1C0, 16'd5);
    repeat (8) step();
    chk_eq("T6 in flight", rd_log.size(), 5);
    reset = 1;
    step();
    chk_eq("T6 ctl zero", {bus.rd_req_valid, bus.wr_req_valid, bus.busy, bus.done}, 4'b0000);
    chk_eq("T6 addr zero", {bus.rd_req_addr, bus.wr_req_addr}, '0);
    chk_eq("T6 data zero", bus.wr_req_data, '0);
    reset = 0;
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      bus.rd_rsp_valid = 1;
      bus.rd_rsp_mdata = 16'(k);
      bus.rd_rsp_data  = line_data(32'(k) + 32'h77);
      step();
    end
    repeat (5) step();
    chk_eq("T6 stray no write", wr_log.size(), 0);
    chk_eq("T6 idle", bus.busy, 0);
    auto_rsp = 1;
    start_job(42'hD00, 42'hE00, 42'h200, 16'd1);
    wait_done("T6b", 50);
    check_job("T6b", 1, 42'hD00, 42'hE00, 42'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
